load_store_unit: RTL and testbench

Byte-addressed load/store front end between the MIPS datapath's MEM stage and `data_mem`. It translates byte addresses into word indices and performs byte/halfword extraction with sign- or zero-extension. Sub-word stores are done as read-modify-write. Misaligned, out-of-range and illegal requests are rejected before they reach memory. A single request is in flight at a time, under a valid/ready handshake.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data_mem signals of the load/store unit, bundled with
// modports for the unit (slave) and for whoever drives requests and memory (master).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] load_data;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, dm_read_data,
        output req_ready, resp_valid, resp_err, load_data,
               dm_read, dm_write, dm_address, dm_write_data
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, dm_read_data,
        input  req_ready, resp_valid, resp_err, load_data,
               dm_read, dm_write, dm_address, dm_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian byte-addressed load/store front end for data_mem, one request in flight.
// Define LSU_SUBWORD_EN to enable LB/LH/LBU/LHU/SB/SH (read-modify-write for sub-word stores).
module load_store_unit #(
    parameter int unsigned DMEM_WORDS = 1024
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD_WAIT,
`ifdef LSU_SUBWORD_EN
        RMW_READ,
        RMW_WAIT,
`endif
        WRITE
    } state_e;

    state_e      state_q, state_d;
    logic [29:0] wordAddr_q, wordAddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] loadData_q, loadData_d;
    logic        respValid_q, respValid_d;
    logic [1:0]  respErr_q, respErr_d;
    logic        opLegal, misaligned, outOfRange;
    logic [1:0]  reqErr;

`ifdef LSU_SUBWORD_EN
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;
    logic [31:0] byteMask, byteData, halfMask, halfData;

    // Lane 0 is the most significant byte/halfword of the word.
    assign ldByte   = 8'(bus.dm_read_data >> {~lane_q, 3'b000});
    assign ldHalf   = 16'(bus.dm_read_data >> {~lane_q[1], 4'b0000});
    assign byteMask = 32'hFF00_0000 >> {lane_q, 3'b000};
    assign byteData = {24'b0, wdata_q[7:0]} << {~lane_q, 3'b000};
    assign halfMask = 32'hFFFF_0000 >> {lane_q[1], 4'b0000};
    assign halfData = {16'b0, wdata_q[15:0]} << {~lane_q[1], 4'b0000};
`endif

    // Accept-time checks; illegal op beats misalignment beats range.
    always_comb begin
        opLegal = 1'b0;
        case (bus.req_op)
`ifdef LSU_SUBWORD_EN
            4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001,
`endif
            4'b0011, 4'b1011: opLegal = 1'b1;
            default:          opLegal = 1'b0;
        endcase
        misaligned = ((bus.req_op[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_op[1:0] == 2'b11) && (bus.req_addr[1:0] != 2'b00));
        outOfRange = {2'b00, bus.req_addr[31:2]} >= DMEM_WORDS;
        if (!opLegal)        reqErr = 2'b11;
        else if (misaligned) reqErr = 2'b01;
        else if (outOfRange) reqErr = 2'b10;
        else                 reqErr = 2'b00;
    end

    always_comb begin
        state_d     = state_q;
        wordAddr_d  = wordAddr_q;
        wdata_d     = wdata_q;
        loadData_d  = loadData_q;
        respValid_d = 1'b0;
        respErr_d   = respErr_q;
`ifdef LSU_SUBWORD_EN
        op_d        = op_q;
        lane_d      = lane_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wordAddr_d = bus.req_addr[31:2];
                    wdata_d    = bus.req_wdata;
`ifdef LSU_SUBWORD_EN
                    op_d       = bus.req_op[2:0];
                    lane_d     = bus.req_addr[1:0];
`endif
                    if (reqErr != 2'b00) begin
                        respValid_d = 1'b1;
                        respErr_d   = reqErr;
                    end else if (!bus.req_op[3]) begin
                        state_d = READ;
`ifdef LSU_SUBWORD_EN
                    end else if (bus.req_op[1:0] != 2'b11) begin
                        state_d = RMW_READ;
`endif
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            READ: state_d = LOAD_WAIT;
            LOAD_WAIT: begin
`ifdef LSU_SUBWORD_EN
                case (op_q[1:0])
                    2'b00:   loadData_d = {{24{ldByte[7] & ~op_q[2]}}, ldByte};
                    2'b01:   loadData_d = {{16{ldHalf[15] & ~op_q[2]}}, ldHalf};
                    default: loadData_d = bus.dm_read_data;
                endcase
`else
                loadData_d = bus.dm_read_data;
`endif
                respValid_d = 1'b1;
                respErr_d   = 2'b00;
                state_d     = IDLE;
            end
`ifdef LSU_SUBWORD_EN
            RMW_READ: state_d = RMW_WAIT;
            RMW_WAIT: begin
                if (op_q[0]) wdata_d = (bus.dm_read_data & ~halfMask) | (halfData & halfMask);
                else         wdata_d = (bus.dm_read_data & ~byteMask) | (byteData & byteMask);
                state_d = WRITE;
            end
`endif
            WRITE: begin
                respValid_d = 1'b1;
                respErr_d   = 2'b00;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wordAddr_q  <= '0;
            wdata_q     <= '0;
            loadData_q  <= '0;
            respValid_q <= 1'b0;
            respErr_q   <= 2'b00;
`ifdef LSU_SUBWORD_EN
            op_q        <= '0;
            lane_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wordAddr_q  <= wordAddr_d;
            wdata_q     <= wdata_d;
            loadData_q  <= loadData_d;
            respValid_q <= respValid_d;
            respErr_q   <= respErr_d;
`ifdef LSU_SUBWORD_EN
            op_q        <= op_d;
            lane_q      <= lane_d;
`endif
        end
    end

    // Strobes are gated by reset so an aborted request never touches memory.
    assign bus.req_ready     = (state_q == IDLE);
    assign bus.resp_valid    = respValid_q;
    assign bus.resp_err      = respErr_q;
    assign bus.load_data     = loadData_q;
`ifdef LSU_SUBWORD_EN
    assign bus.dm_read       = !reset && ((state_q == READ) || (state_q == RMW_READ));
`else
    assign bus.dm_read       = !reset && (state_q == READ);
`endif
    assign bus.dm_write      = !reset && (state_q == WRITE);
    assign bus.dm_address    = (state_q != IDLE) ? {2'b00, wordAddr_q} : 32'h0;
    assign bus.dm_write_data = (state_q == WRITE) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts each
// response at accept time, and a negedge monitor checks responses as they appear.
module tb_load_store_unit;
   localparam int WORDS = 1024;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   load_store_unit_if bus();

   load_store_unit #(.DMEM_WORDS(WORDS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Word-wide data_mem with a registered read port.
   logic [31:0] mem [0:WORDS-1];
   logic [31:0] memRdata = 32'h0;
   assign bus.dm_read_data = memRdata;
   always @(posedge clk) begin
      if (bus.dm_read)
         memRdata <= (bus.dm_address < WORDS) ? mem[bus.dm_address[9:0]] : 32'hDEAD0000;
      if (bus.dm_write && bus.dm_address < WORDS)
         mem[bus.dm_address[9:0]] = bus.dm_write_data;
   end

   // Reference model state: memory as big-endian bytes plus the last load result.
   logic [7:0]  refMem [0:4*WORDS-1];
   logic [31:0] modelLoad;

   typedef struct {
      logic [1:0]  err;
      logic [31:0] data;
      int          due;
      int          rd;
      int          wr;
   } expT;

   expT sbQ[$];
   expT monE;
   int total = 0;
   int bad = 0;
   int cycCount = 0;
   int rdCnt = 0;
   int wrCnt = 0;
   logic [31:0] lastWriteData = 32'h0;
   int waited;

   always @(posedge clk) cycCount <= cycCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic setWord(input int idx, input logic [31:0] w);
      mem[idx] = w;
      for (int b = 0; b < 4; b++) refMem[4*idx+b] = 8'(w >> (24 - 8*b));
   endtask

   function automatic expT model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int acceptCycle);
      expT e;
      logic legal;
      int nb;
      logic [31:0] v;
`ifdef LSU_SUBWORD_EN
      legal = op inside {4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011};
`else
      legal = op inside {4'b0011, 4'b1011};
`endif
      nb = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
      e.rd = 0;
      e.wr = 0;
      if (!legal)                 e.err = 2'b11;
      else if (addr % nb != 0)    e.err = 2'b01;
      else if (addr >= 4*WORDS)   e.err = 2'b10;
      else                        e.err = 2'b00;
      if (e.err != 2'b00) begin
         e.due = acceptCycle + 1;
      end else if (!op[3]) begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = (v << 8) | {24'h0, refMem[addr+i]};
         if (nb < 4 && !op[2] && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
         modelLoad = v;
         e.rd  = 1;
         e.due = acceptCycle + 3;
      end else begin
         for (int i = 0; i < nb; i++) refMem[addr+i] = 8'(wdata >> (8*(nb-1-i)));
         e.wr = 1;
         if (nb == 4) e.due = acceptCycle + 2;
         else begin
            e.rd  = 1;
            e.due = acceptCycle + 4;
         end
      end
      e.data = modelLoad;
      return e;
   endfunction

   // Called mid-cycle; returns mid-cycle after the accept.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit abortIt, output int waitCnt);
      waitCnt = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      if (waitCnt >= 20) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout actual=ready_low required=ready_high");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!abortIt) sbQ.push_back(model(op, addr, wdata, cycCount - 1));
      bus.req_valid = 1'b0;
      bus.req_op    = 4'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      @(negedge clk);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (sbQ.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (sbQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain actual=%0d_pending required=0", sbQ.size());
         sbQ.delete();
      end
   endtask

   // Monitor: strobe counts and response checks, decoupled from stimulus.
   always @(negedge clk) begin
      if (reset) begin
         checkOutput("strobe_in_reset", {30'h0, bus.dm_read, bus.dm_write}, 32'h0);
         rdCnt = 0;
         wrCnt = 0;
      end else begin
         rdCnt += int'(bus.dm_read);
         wrCnt += int'(bus.dm_write);
         if (bus.dm_write) lastWriteData = bus.dm_write_data;
         if (bus.resp_valid) begin
            if (sbQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_resp actual=resp_valid required=none err=%b", bus.resp_err);
            end else begin
               monE = sbQ.pop_front();
               checkOutput("resp_cycle", cycCount, monE.due);
               checkOutput("resp_err", {30'h0, bus.resp_err}, {30'h0, monE.err});
               checkOutput("load_data", bus.load_data, monE.data);
               checkOutput("read_strobes", rdCnt, monE.rd);
               checkOutput("write_strobes", wrCnt, monE.wr);
            end
            rdCnt = 0;
            wrCnt = 0;
         end else if (sbQ.size() != 0 && cycCount > sbQ[0].due) begin
            total++;
            bad++;
            $display("[TB] FAIL resp_timeout actual=no_resp required=resp_at_cycle_%0d", sbQ[0].due);
            void'(sbQ.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] legalOps [8];
      logic [3:0] op;
      logic [31:0] addr;
      legalOps = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011};

      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'h0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      modelLoad     = 32'h0;
      for (int i = 0; i < WORDS; i++) setWord(i, $urandom);
      setWord(4, 32'h8899AABB);

      repeat (3) @(negedge clk);
      reset = 1'b0;
      checkOutput("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
      checkOutput("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      checkOutput("reset_resp_err", {30'h0, bus.resp_err}, 32'h0);
      checkOutput("reset_load_data", bus.load_data, 32'h0);
      checkOutput("reset_dm_strobes", {30'h0, bus.dm_read, bus.dm_write}, 32'h0);
      checkOutput("reset_dm_address", bus.dm_address, 32'h0);
      checkOutput("reset_dm_write_data", bus.dm_write_data, 32'h0);

      applyStimulus(4'b0011, 32'h10, 32'h0, 0, waited);
      waitIdle();
      checkOutput("lw_0x10_value", bus.load_data, 32'h8899AABB);

      applyStimulus(4'b0000, 32'h10, 32'h0, 0, waited);
      waitIdle();
`ifdef LSU_SUBWORD_EN
      checkOutput("lb_0x10_value", bus.load_data, 32'hFFFFFF88);
`endif
      applyStimulus(4'b0100, 32'h13, 32'h0, 0, waited);
      waitIdle();
`ifdef LSU_SUBWORD_EN
      checkOutput("lbu_0x13_value", bus.load_data, 32'h000000BB);
`endif
      applyStimulus(4'b0001, 32'h12, 32'h0, 0, waited);
      waitIdle();
`ifdef LSU_SUBWORD_EN
      checkOutput("lh_0x12_value", bus.load_data, 32'hFFFFAABB);
`endif
      applyStimulus(4'b0101, 32'h10, 32'h0, 0, waited);
      waitIdle();
`ifdef LSU_SUBWORD_EN
      checkOutput("lhu_0x10_value", bus.load_data, 32'h00008899);
`endif
      applyStimulus(4'b1000, 32'h11, 32'h12345677, 0, waited);
      waitIdle();
`ifdef LSU_SUBWORD_EN
      checkOutput("sb_write_data", lastWriteData, 32'h8877AABB);
`endif
      applyStimulus(4'b0011, 32'h10, 32'h0, 0, waited);
      waitIdle();
`ifdef LSU_SUBWORD_EN
      checkOutput("lw_after_sb", bus.load_data, 32'h8877AABB);
`else
      checkOutput("lw_after_sb", bus.load_data, 32'h8899AABB);
`endif

      // Error cases and the range boundary, including priority between checks.
      applyStimulus(4'b0011, 32'h12,   32'h0, 0, waited);
      applyStimulus(4'b1001, 32'h11,   32'h0, 0, waited);
      applyStimulus(4'b0011, 32'h1000, 32'h0, 0, waited);
      applyStimulus(4'b0111, 32'h10,   32'h0, 0, waited);
      applyStimulus(4'b0111, 32'h13,   32'h0, 0, waited);
      applyStimulus(4'b0011, 32'h1002, 32'h0, 0, waited);
      applyStimulus(4'b0011, 32'hFFC,  32'h0, 0, waited);
      applyStimulus(4'b1011, 32'hFFC,  32'h5A5A1234, 0, waited);
      applyStimulus(4'b0011, 32'hFFC,  32'h0, 0, waited);
      waitIdle();

      // Reset in the middle of a store: nothing written, no response.
`ifdef LSU_SUBWORD_EN
      applyStimulus(4'b1001, 32'h10, 32'h0000CAFE, 1, waited);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
`else
      applyStimulus(4'b1011, 32'h10, 32'hCAFE0000, 1, waited);
      reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
`endif
      modelLoad = 32'h0;
      checkOutput("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
      checkOutput("load_data_after_reset", bus.load_data, 32'h0);
      applyStimulus(4'b0011, 32'h10, 32'h0, 0, waited);
      waitIdle();
`ifdef LSU_SUBWORD_EN
      checkOutput("word4_after_abort", bus.load_data, 32'h8877AABB);
`else
      checkOutput("word4_after_abort", bus.load_data, 32'h8899AABB);
`endif

      // Back-to-back: the load is offered while the store is still writing.
      applyStimulus(4'b1011, 32'h20, 32'hDEADBEEF, 0, waited);
      applyStimulus(4'b0011, 32'h20, 32'h0, 0, waited);
      checkOutput("b2b_accept_wait", waited, 32'd1);
      waitIdle();
      checkOutput("b2b_lw_value", bus.load_data, 32'hDEADBEEF);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) < 8) op = legalOps[$urandom_range(0, 7)];
         else                          op = 4'($urandom);
         case ($urandom_range(0, 9))
            8:       addr = 32'(4*WORDS - 4) + 32'($urandom_range(0, 7));
            9:       addr = $urandom;
            default: addr = 32'($urandom_range(0, 63));
         endcase
         applyStimulus(op, addr, $urandom, 0, waited);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      waitIdle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
